irq_combiner: RTL

IRQ_COMBINER -- requirements
Module: irq_combiner

---
 rtl/irq_combiner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/irq_combiner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_combiner: edge-detects N async request lines into sticky pending bits  |
// | and offers the lowest enabled pending index over a valid/ready handshake.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module irq_combiner #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 mask_wr,
  input  logic [N-1:0]         mask_in,
  output logic [N-1:0]         mask_q,
  output logic [N-1:0]         pending_q,
  output logic                 irq_any,
  output logic                 irq_valid,
  output logic [$clog2(N)-1:0] irq_id,
  input  logic                 irq_ready
);

  localparam int IDW = $clog2(N);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [N-1:0]   r_sync1;
  logic [N-1:0]   r_sync2;
  logic [N-1:0]   r_sync3;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   r_mask;
  logic           r_any;
  logic [IDW-1:0] r_id;
  logic [0:0]     r_state;
  logic [0:0]     w_state_nxt;

  logic [N-1:0]   w_rise;
  logic [N-1:0]   w_active;
  logic [N-1:0]   w_clr;
  logic [IDW-1:0] w_sel;
  logic           w_handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= req;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise      = r_sync2 & ~r_sync3;
  assign w_active    = r_pending & r_mask;
  assign w_handshake = (r_state == S_PRESENT) && irq_ready;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N; i++) begin
      w_clr[i] = w_handshake && (r_id == IDW'(i));
    end
  end

  // Descending scan so the lowest active index is the final assignment.
  always_comb begin
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_sel = IDW'(i);
      end
    end
  end

  // A rise in the clearing cycle wins, so the new event is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_mask    <= '1;
      r_any     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_any     <= |w_active;
      if (mask_wr) begin
        r_mask <= mask_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (|w_active) w_state_nxt = S_PRESENT;
      S_PRESENT: if (irq_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // The offered id is frozen for the whole PRESENT interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id <= '0;
    end else if ((r_state == S_IDLE) && (|w_active)) begin
      r_id <= w_sel;
    end
  end

  always_comb begin
    irq_valid = (r_state == S_PRESENT);
  end

  assign mask_q    = r_mask;
  assign pending_q = r_pending;
  assign irq_any   = r_any;
  assign irq_id    = r_id;

endmodule
`default_nettype wire
